// File: rtl/pll_ctrl_pkg.sv
// Shared types and 27 MHz timing defaults for the rPLL supervisor.
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_HOLD      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_LOCKED    = 3'd3,
    ST_FAULT     = 3'd4
  } pll_state_e;

  // One rPLL dynamic divider select code (IDSEL/FBDSEL/ODSEL).
  typedef logic [5:0] dsel_t;

  // Timing defaults for a 27 MHz reference clock.
  localparam int unsigned DEF_RST_HOLD_CYC    = 27;      // >= 1 us of PLL reset
  localparam int unsigned DEF_LOCK_STABLE_CYC = 1024;    // lock qualification window
  localparam int unsigned DEF_LOCK_TIMEOUT_CYC = 270000; // 10 ms per lock attempt
  localparam int unsigned DEF_MAX_RETRY       = 3;

  // Largest of three cycle counts; sizes the shared sequencing counter.
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_reconfig_ctrl_sync_2ff.sv
// Generic 1-bit two-flop synchronizer, cleared to 0 on reset.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops give metastability one full cycle to resolve.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_reconfig_ctrl.sv
// rPLL supervisor: applies divider codes, sequences PLL reset, qualifies
// LOCK over a stability window, retries failed locks and reports a sticky fault.
//
// Handshake: a request transfers on a clkin edge where cfg_valid & cfg_ready.
// cfg_ready is high only in LOCKED or FAULT; while a sequence is running
// (busy) cfg_valid is ignored and nothing is queued. An accepted request
// latches cfg_* into pll_*sel and restarts the sequence from HOLD.
module pll_reconfig_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter logic [5:0]  DEF_IDSEL        = 6'd0,
  parameter logic [5:0]  DEF_FBDSEL       = 6'd0,
  parameter logic [5:0]  DEF_ODSEL        = 6'd0,
  parameter int unsigned RST_HOLD_CYC     = DEF_RST_HOLD_CYC,
  parameter int unsigned LOCK_STABLE_CYC  = DEF_LOCK_STABLE_CYC,
  parameter int unsigned LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
  parameter int unsigned MAX_RETRY        = DEF_MAX_RETRY
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [5:0] cfg_idsel,
  input  logic [5:0] cfg_fbdsel,
  input  logic [5:0] cfg_odsel,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic [5:0] pll_idsel,
  output logic [5:0] pll_fbdsel,
  output logic [5:0] pll_odsel,
  output logic       locked,
  output logic       busy,
  output logic       fault,
  output logic [2:0] dbg_state_o,
  output logic [3:0] dbg_retry_o
);

  localparam int unsigned CNT_SPAN = max3(LOCK_TIMEOUT_CYC, LOCK_STABLE_CYC, RST_HOLD_CYC);
  localparam int CNT_W = (CNT_SPAN > 1) ? $clog2(CNT_SPAN) : 1;
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] STB_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = '1;
  localparam logic [RTY_W-1:0] RTY_MAX   = RTY_W'(MAX_RETRY);

  pll_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [RTY_W-1:0] retry_q, retry_d;
  dsel_t            idsel_q, fbdsel_q, odsel_q;
  logic             load_cfg;
  logic             lock_s;

  sync_2ff u_lock_sync (
    .clk_i (clkin),
    .rst_i (reset),
    .d_i   (pll_lock),
    .q_o   (lock_s)
  );

  // Saturating increment so the counter can never wrap back into a match.
  assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;

  // State, counter, retry count and the applied divider codes.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state_q  <= ST_HOLD;
      cnt_q    <= '0;
      retry_q  <= '0;
      idsel_q  <= DEF_IDSEL;
      fbdsel_q <= DEF_FBDSEL;
      odsel_q  <= DEF_ODSEL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      if (load_cfg) begin
        idsel_q  <= cfg_idsel;
        fbdsel_q <= cfg_fbdsel;
        odsel_q  <= cfg_odsel;
      end
    end
  end

  // Next-state, counter and retry bookkeeping.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    retry_d  = retry_q;
    load_cfg = 1'b0;
    case (state_q)
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TMO_LAST) begin
          cnt_d = '0;
          if (retry_q < RTY_MAX) begin
            retry_d = retry_q + 1'b1;
            state_d = ST_HOLD;
          end else begin
            state_d = ST_FAULT;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_STABLE: begin
        // A dropout restarts the attempt but is not counted as a failure.
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STB_LAST) begin
          state_d = ST_LOCKED;
          cnt_d   = '0;
          retry_d = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_LOCKED: begin
        // A request beats a simultaneous lock loss: the new codes get applied.
        if (cfg_valid) begin
          load_cfg = 1'b1;
          retry_d  = '0;
          state_d  = ST_HOLD;
          cnt_d    = '0;
        end else if (!lock_s) begin
          cnt_d = '0;
          if (retry_q < RTY_MAX) begin
            retry_d = retry_q + 1'b1;
            state_d = ST_HOLD;
          end else begin
            state_d = ST_FAULT;
          end
        end
      end
      ST_FAULT: begin
        if (cfg_valid) begin
          load_cfg = 1'b1;
          retry_d  = '0;
          state_d  = ST_HOLD;
          cnt_d    = '0;
        end
      end
      default: begin
        state_d = ST_HOLD;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decoded from the current state so async reset acts immediately.
  always_comb begin
    pll_reset = 1'b0;
    locked    = 1'b0;
    busy      = 1'b0;
    fault     = 1'b0;
    cfg_ready = 1'b0;
    case (state_q)
      ST_HOLD: begin
        pll_reset = 1'b1;
        busy      = 1'b1;
      end
      ST_WAIT_LOCK, ST_STABLE: begin
        busy = 1'b1;
      end
      ST_LOCKED: begin
        locked    = 1'b1;
        cfg_ready = 1'b1;
      end
      ST_FAULT: begin
        pll_reset = 1'b1;
        fault     = 1'b1;
        cfg_ready = 1'b1;
      end
      default: begin
        pll_reset = 1'b1;
        busy      = 1'b1;
      end
    endcase
  end

  assign pll_idsel   = idsel_q;
  assign pll_fbdsel  = fbdsel_q;
  assign pll_odsel   = odsel_q;
  assign dbg_state_o = state_q;
  assign dbg_retry_o = 4'(retry_q);

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Directed bench for pll_reconfig_ctrl with short timing parameters.
module tb_pll_reconfig_ctrl;

  localparam logic [5:0] T_DEF_ID = 6'h05;
  localparam logic [5:0] T_DEF_FB = 6'h0A;
  localparam logic [5:0] T_DEF_OD = 6'h11;

  localparam logic [31:0] S_HOLD   = 32'd0;
  localparam logic [31:0] S_WAIT   = 32'd1;
  localparam logic [31:0] S_STABLE = 32'd2;
  localparam logic [31:0] S_FAULT  = 32'd4;

  logic       clkin;
  logic       reset;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [5:0] cfg_idsel, cfg_fbdsel, cfg_odsel;
  logic       pll_lock;
  logic       pll_reset;
  logic [5:0] pll_idsel, pll_fbdsel, pll_odsel;
  logic       locked, busy, fault;
  logic [2:0] dbg_state_o;
  logic [3:0] dbg_retry_o;

  int total = 0;
  int bad   = 0;

  logic [17:0] exp_q[$];
  logic [17:0] cur_sel;

  pll_reconfig_ctrl #(
    .DEF_IDSEL        (T_DEF_ID),
    .DEF_FBDSEL       (T_DEF_FB),
    .DEF_ODSEL        (T_DEF_OD),
    .RST_HOLD_CYC     (4),
    .LOCK_STABLE_CYC  (8),
    .LOCK_TIMEOUT_CYC (32),
    .MAX_RETRY        (2)
  ) dut (
    .clkin       (clkin),
    .reset       (reset),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_idsel   (cfg_idsel),
    .cfg_fbdsel  (cfg_fbdsel),
    .cfg_odsel   (cfg_odsel),
    .pll_lock    (pll_lock),
    .pll_reset   (pll_reset),
    .pll_idsel   (pll_idsel),
    .pll_fbdsel  (pll_fbdsel),
    .pll_odsel   (pll_odsel),
    .locked      (locked),
    .busy        (busy),
    .fault       (fault),
    .dbg_state_o (dbg_state_o),
    .dbg_retry_o (dbg_retry_o)
  );

  // clock / reset block
  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clkin);
      #1;
    end
  endtask

  task automatic send_cfg(input logic [5:0] id, input logic [5:0] fb, input logic [5:0] od);
    cfg_idsel  = id;
    cfg_fbdsel = fb;
    cfg_odsel  = od;
    cfg_valid  = 1'b1;
  endtask

  // scoreboard
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_sel_change(input string tag);
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s: observed=empty expected=queued code", tag);
    end else begin
      cur_sel = exp_q.pop_front();
      check(tag, 32'({pll_idsel, pll_fbdsel, pll_odsel}), 32'(cur_sel));
    end
  endtask

  task automatic check_sel_hold(input string tag);
    check(tag, 32'({pll_idsel, pll_fbdsel, pll_odsel}), 32'(cur_sel));
  endtask

  initial begin
    reset     = 1'b1;
    cfg_valid = 1'b0;
    cfg_idsel = 6'h00;
    cfg_fbdsel = 6'h00;
    cfg_odsel = 6'h00;
    pll_lock  = 1'b0;
    exp_q.push_back({T_DEF_ID, T_DEF_FB, T_DEF_OD});

    // reset state
    tick(2);
    check("rst_state", 32'(dbg_state_o), S_HOLD);
    check("rst_pll_reset", 32'(pll_reset), 32'd1);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd0);
    check("rst_retry", 32'(dbg_retry_o), 32'd0);
    check_sel_change("rst_sel");

    // power-up: pll_reset high for exactly 4 cycles
    reset = 1'b0;
    tick(3);
    check("pu_hold_3", 32'(pll_reset), 32'd1);
    tick(1);
    check("pu_hold_end", 32'(pll_reset), 32'd0);
    check("pu_wait", 32'(dbg_state_o), S_WAIT);

    // lock rises; locked follows 2 + 8 + 1 edges later
    tick(6);
    pll_lock = 1'b1;
    tick(2);
    check("pu_sync_lat", 32'(dbg_state_o), S_WAIT);
    tick(1);
    check("pu_stable", 32'(dbg_state_o), S_STABLE);
    tick(7);
    check("pu_locked_10", 32'(locked), 32'd0);
    tick(1);
    check("pu_locked_11", 32'(locked), 32'd1);
    check("pu_busy", 32'(busy), 32'd0);
    check("pu_cfg_ready", 32'(cfg_ready), 32'd1);
    check_sel_hold("pu_sel_def");

    // reconfiguration from LOCKED
    send_cfg(6'h3A, 6'h33, 6'h38);
    exp_q.push_back({6'h3A, 6'h33, 6'h38});
    tick(1);
    cfg_valid = 1'b0;
    check("rc_cfg_ready", 32'(cfg_ready), 32'd0);
    check("rc_state", 32'(dbg_state_o), S_HOLD);
    check("rc_locked", 32'(locked), 32'd0);
    check("rc_pll_reset", 32'(pll_reset), 32'd1);
    check_sel_change("rc_sel");
    tick(3);
    check("rc_hold_3", 32'(pll_reset), 32'd1);
    tick(1);
    check("rc_hold_end", 32'(pll_reset), 32'd0);
    tick(1);
    check("rc_stable", 32'(dbg_state_o), S_STABLE);
    tick(7);
    check("rc_locked_early", 32'(locked), 32'd0);
    tick(1);
    check("rc_relocked", 32'(locked), 32'd1);
    check("rc_retry", 32'(dbg_retry_o), 32'd0);
    check_sel_hold("rc_sel_hold");

    // lock loss in LOCKED: locked drops on the third edge
    pll_lock = 1'b0;
    tick(2);
    check("ll_locked_2", 32'(locked), 32'd1);
    tick(1);
    check("ll_locked_3", 32'(locked), 32'd0);
    check("ll_pll_reset", 32'(pll_reset), 32'd1);
    check("ll_retry", 32'(dbg_retry_o), 32'd1);
    check("ll_state", 32'(dbg_state_o), S_HOLD);

    // glitch in STABLE after 5 stable cycles
    tick(4);
    check("gl_wait", 32'(dbg_state_o), S_WAIT);
    pll_lock = 1'b1;
    tick(3);
    check("gl_stable", 32'(dbg_state_o), S_STABLE);
    tick(5);
    pll_lock = 1'b0;
    tick(1);
    pll_lock = 1'b1;
    tick(1);
    check("gl_no_lock", 32'(locked), 32'd0);
    tick(1);
    check("gl_back_wait", 32'(dbg_state_o), S_WAIT);
    check("gl_retry_kept", 32'(dbg_retry_o), 32'd1);
    tick(1);
    check("gl_restable", 32'(dbg_state_o), S_STABLE);
    tick(7);
    check("gl_locked_early", 32'(locked), 32'd0);
    tick(1);
    check("gl_locked", 32'(locked), 32'd1);
    check("gl_retry_clr", 32'(dbg_retry_o), 32'd0);

    // timeout / fault: request new codes while the PLL stays unlocked
    send_cfg(6'h15, 6'h2A, 6'h07);
    exp_q.push_back({6'h15, 6'h2A, 6'h07});
    pll_lock = 1'b0;
    tick(1);
    cfg_valid = 1'b0;
    check("to_state", 32'(dbg_state_o), S_HOLD);
    check_sel_change("to_sel");
    tick(4);
    check("to_w1_start", 32'(dbg_state_o), S_WAIT);
    tick(31);
    check("to_w1_last", 32'(dbg_state_o), S_WAIT);
    tick(1);
    check("to_w1_end", 32'(dbg_state_o), S_HOLD);
    check("to_retry1", 32'(dbg_retry_o), 32'd1);
    tick(4);
    check("to_w2_start", 32'(dbg_state_o), S_WAIT);
    send_cfg(6'h01, 6'h02, 6'h03);
    tick(1);
    cfg_valid = 1'b0;
    check("to_busy_ignore_st", 32'(dbg_state_o), S_WAIT);
    check("to_busy_ready", 32'(cfg_ready), 32'd0);
    check_sel_hold("to_busy_ignore_sel");
    tick(30);
    check("to_w2_last", 32'(dbg_state_o), S_WAIT);
    tick(1);
    check("to_w2_end", 32'(dbg_state_o), S_HOLD);
    check("to_retry2", 32'(dbg_retry_o), 32'd2);
    tick(4);
    check("to_w3_start", 32'(dbg_state_o), S_WAIT);
    tick(31);
    check("to_w3_last", 32'(dbg_state_o), S_WAIT);
    tick(1);
    check("to_fault_state", 32'(dbg_state_o), S_FAULT);
    check("to_fault", 32'(fault), 32'd1);
    check("to_fault_ready", 32'(cfg_ready), 32'd1);
    check("to_fault_rst", 32'(pll_reset), 32'd1);
    check("to_fault_busy", 32'(busy), 32'd0);
    tick(5);
    check("to_fault_sticky", 32'(fault), 32'd1);
    send_cfg(6'h3F, 6'h00, 6'h2B);
    exp_q.push_back({6'h3F, 6'h00, 6'h2B});
    tick(1);
    cfg_valid = 1'b0;
    check("fc_fault_clr", 32'(fault), 32'd0);
    check("fc_state", 32'(dbg_state_o), S_HOLD);
    check("fc_retry", 32'(dbg_retry_o), 32'd0);
    check_sel_change("fc_sel");

    // async reset in the middle of WAIT_LOCK, checked before the next edge
    tick(4);
    check("ar_wait", 32'(dbg_state_o), S_WAIT);
    tick(5);
    #2;
    reset = 1'b1;
    exp_q.push_back({T_DEF_ID, T_DEF_FB, T_DEF_OD});
    #1;
    check("ar_state", 32'(dbg_state_o), S_HOLD);
    check("ar_pll_reset", 32'(pll_reset), 32'd1);
    check("ar_busy", 32'(busy), 32'd1);
    check("ar_locked", 32'(locked), 32'd0);
    check("ar_fault", 32'(fault), 32'd0);
    check("ar_cfg_ready", 32'(cfg_ready), 32'd0);
    check("ar_retry", 32'(dbg_retry_o), 32'd0);
    check_sel_change("ar_sel");
    tick(2);
    reset = 1'b0;
    tick(1);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pll_reconfig_ctrl.md
Name: pll_reconfig_ctrl

Overview:
- Supervises the on-chip rPLL; runs on the 27 MHz board reference clock, never on PLL output.
- Applies dynamic divider codes (IDSEL/FBDSEL/ODSEL) and sequences PLL reset, then qualifies LOCK with a stability window.
- Produces a clean `locked` status for downstream reset generation.
- Accepts runtime reconfiguration requests via a valid/ready handshake, retries failed locks, and reports a sticky fault.

Parameters:
- DEF_IDSEL, 6'd0, divider code applied after reset
- DEF_FBDSEL, 6'd0, feedback code applied after reset
- DEF_ODSEL, 6'd0, output code applied after reset
- RST_HOLD_CYC, 27, clkin cycles pll_reset held high (≥1 µs @27 MHz)
- LOCK_STABLE_CYC, 1024, consecutive cycles of synced lock required
- LOCK_TIMEOUT_CYC, 270000, max cycles in WAIT_LOCK (10 ms)
- MAX_RETRY, 3, relock attempts before FAULT

Ports:
- clkin  in  1  reference clock (27 MHz)
- reset  in  1  asynchronous, active-high
- cfg_valid  in  1  reconfiguration request
- cfg_ready  out  1  high only in LOCKED or FAULT
- cfg_idsel  in  6  requested IDSEL code
- cfg_fbdsel  in  6  requested FBDSEL code
- cfg_odsel  in  6  requested ODSEL code
- pll_lock  in  1  raw PLL LOCK (asynchronous to clkin)
- pll_reset  out  1  to PLL RESET
- pll_idsel  out  6  to PLL IDSEL
- pll_fbdsel  out  6  to PLL FBDSEL
- pll_odsel  out  6  to PLL ODSEL
- locked  out  1  qualified lock
- busy  out  1  sequence in progress
- fault  out  1  sticky, retries exhausted

Behaviour:
- Reset values: state=HOLD, pll_reset=1, pll_*sel=DEF_*, locked=0, busy=1, fault=0, cfg_ready=0, counters=0, retry=0.
- pll_lock passes through a 2-flop synchronizer (lock_s). Lock-path latency is 2 cycles.
- HOLD: pll_reset=1; count RST_HOLD_CYC cycles, then go to WAIT_LOCK and clear the counter. pll_reset falls on the transition cycle.
- WAIT_LOCK: pll_reset=0; the counter increments each cycle.
  - lock_s=1 → go to STABLE and clear the counter.
  - Counter reaches LOCK_TIMEOUT_CYC-1 → retry check (below).
- STABLE: the counter increments while lock_s=1.
  - lock_s=0 → return to WAIT_LOCK; the timeout counter restarts from 0 and the retry count is not consumed.
  - Counter reaches LOCK_STABLE_CYC-1 → go to LOCKED and clear retry. `locked` rises on the next edge.
- LOCKED: locked=1, busy=0, cfg_ready=1.
  - lock_s=0 → go to HOLD immediately with locked=0 the same edge. This is an unexpected loss and consumes a retry.
  - cfg_valid=1 → latch cfg_* into pll_*sel, clear retry, go to HOLD. locked drops next edge.
  - If lock loss and cfg_valid occur in the same cycle, the request wins and the new codes are latched.
- Retry check: if retry<MAX_RETRY, increment retry and go to HOLD; otherwise go to FAULT.
- FAULT: pll_reset=1, locked=0, busy=0, fault=1, cfg_ready=1.
  - Only cfg_valid (which latches codes, clears fault and retry, and goes to HOLD) or reset exits this state.
- Handshake: transfer occurs when cfg_valid & cfg_ready. cfg_valid is ignored while busy; there is no queuing.
- pll_*sel change only on an accepted transfer or on reset, and are stable throughout HOLD/WAIT/STABLE.
- Mid-operation reset returns to the reset values asynchronously. pll_reset asserts immediately.
- Counter width is clog2(max(LOCK_TIMEOUT_CYC, LOCK_STABLE_CYC, RST_HOLD_CYC)). Counters saturate and never wrap.

Decomposition:
- Shared package pll_ctrl_pkg:
  - state enum {HOLD, WAIT_LOCK, STABLE, LOCKED, FAULT}
  - 6-bit dyn-select code typedef
  - default timing constants for 27 MHz
- Sub-module sync_2ff: a generic 1-bit 2-flop synchronizer, with reset to 0, used for pll_lock.

Test Plan (all cases use RST_HOLD_CYC=4, LOCK_STABLE_CYC=8, LOCK_TIMEOUT_CYC=32, MAX_RETRY=2):
- Power-up: deassert reset, raise pll_lock at cycle 10 → pll_reset high for exactly 4 cycles, locked=1 at 2+8+1 cycles after lock rise; pll_*sel=DEF_*.
- Glitch in STABLE: drop pll_lock for 1 cycle after 5 stable cycles → locked stays 0, stable count restarts, locked rises 8 cycles after recovery; retry unchanged.
- Reconfig: in LOCKED, drive cfg_valid with idsel=6'h3A, fbdsel=6'h33, odsel=6'h38 → cfg_ready drops next cycle, pll_*sel show new codes, pll_reset pulses 4 cycles, relock completes.
- Timeout/fault: hold pll_lock=0 → three 32-cycle WAIT_LOCK windows separated by HOLD, then fault=1, cfg_ready=1, pll_reset=1; a following cfg_valid clears fault.
- Lock loss in LOCKED: drop pll_lock → locked=0 within 3 cycles (2 sync + 1), pll_reset=1, retry=1.
- Async reset mid-WAIT_LOCK → all outputs return to reset values before the next clkin edge.
